// File: rtl/gpio_bank.sv
// N-pin GPIO bank: register file, pad drive, synchronised/debounced inputs
// and sticky edge interrupts ORed onto a single irq line.

module gpio_bank_pin #(
    parameter int DEB_CYCLES = 4,
    parameter int CNT_W      = $clog2(DEB_CYCLES+1)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic y,
    input  logic deb_en,
    output logic q,
    output logic rise,
    output logic fall
);
    logic             s1, s2, q_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;

    always_comb begin
        q_nxt   = q;
        cnt_nxt = cnt;
        if (s2 == q) begin
            cnt_nxt = '0;
        end else if (!deb_en || cnt == CNT_W'(DEB_CYCLES-1)) begin
            q_nxt   = s2;
            cnt_nxt = '0;
        end else begin
            cnt_nxt = cnt + CNT_W'(1);
        end
    end

    // Edge pulses are combinational so flags set on the same edge as q.
    assign rise = q_nxt & ~q;
    assign fall = ~q_nxt & q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1  <= 1'b0;
            s2  <= 1'b0;
            q   <= 1'b0;
            cnt <= '0;
        end else begin
            s1  <= y;
            s2  <= s1;
            q   <= q_nxt;
            cnt <= cnt_nxt;
        end
    end
endmodule

module gpio_bank #(
    parameter int WIDTH      = 8,
    parameter int DEB_CYCLES = 4,
    parameter int CNT_W      = $clog2(DEB_CYCLES+1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic             rd_en,
    input  logic [3:0]       addr,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] rd_data,
    output logic [WIDTH-1:0] pad_a,
    output logic [WIDTH-1:0] pad_oe,
    output logic [WIDTH-1:0] pad_pu,
    output logic [WIDTH-1:0] pad_pd,
    input  logic [WIDTH-1:0] pad_y,
    output logic             irq
);
    logic [WIDTH-1:0] dout, oe, pu, pd, rise_en, fall_en, deb_en, irq_status;
    logic [WIDTH-1:0] din, rise, fall, clr, status_nxt, rd_mux;

    gpio_bank_pin #(.DEB_CYCLES(DEB_CYCLES), .CNT_W(CNT_W)) u_pin [WIDTH-1:0] (
        .clk    (clk),
        .rst_n  (rst_n),
        .y      (pad_y),
        .deb_en (deb_en),
        .q      (din),
        .rise   (rise),
        .fall   (fall)
    );

    assign pad_a  = dout;
    assign pad_oe = oe;
    assign pad_pu = pu;
    assign pad_pd = pd & ~pu;

    // Set is ORed in after the clear so a colliding set wins.
    assign clr        = (wr_en && addr == 4'd7) ? wr_data : '0;
    assign status_nxt = (irq_status & ~clr) | (rise & rise_en) | (fall & fall_en);

    always_comb begin
        rd_mux = '0;
        case (addr)
            4'd0: rd_mux = dout;
            4'd1: rd_mux = oe;
            4'd2: rd_mux = pu;
            4'd3: rd_mux = pd;
            4'd4: rd_mux = rise_en;
            4'd5: rd_mux = fall_en;
            4'd6: rd_mux = deb_en;
            4'd7: rd_mux = irq_status;
            4'd8: rd_mux = din;
            default: rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout       <= '0;
            oe         <= '0;
            pu         <= '0;
            pd         <= '0;
            rise_en    <= '0;
            fall_en    <= '0;
            deb_en     <= '0;
            irq_status <= '0;
            rd_data    <= '0;
            irq        <= 1'b0;
        end else begin
            if (wr_en) begin
                case (addr)
                    4'd0: dout    <= wr_data;
                    4'd1: oe      <= wr_data;
                    4'd2: pu      <= wr_data;
                    4'd3: pd      <= wr_data;
                    4'd4: rise_en <= wr_data;
                    4'd5: fall_en <= wr_data;
                    4'd6: deb_en  <= wr_data;
                    default: ;
                endcase
            end
            irq_status <= status_nxt;
            irq        <= |irq_status;
            if (rd_en) rd_data <= rd_mux;
        end
    end
endmodule

// File: tb/tb_gpio_bank.sv
// Directed bench for gpio_bank: register access, pad drive, sync latency,
// debounce, set/clear collision and async reset mid-debounce.

module tb_gpio_bank;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       wr_en = 1'b0;
    logic       rd_en = 1'b0;
    logic [3:0] addr = '0;
    logic [7:0] wr_data = '0;
    logic [7:0] rd_data, pad_a, pad_oe, pad_pu, pad_pd;
    logic [7:0] pad_y = 8'h02;
    logic       irq;
    int         total = 0;
    int         bad = 0;

    gpio_bank #(.WIDTH(8), .DEB_CYCLES(4)) dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .rd_en(rd_en), .addr(addr),
        .wr_data(wr_data), .rd_data(rd_data), .pad_a(pad_a), .pad_oe(pad_oe),
        .pad_pu(pad_pu), .pad_pd(pad_pd), .pad_y(pad_y), .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // All tasks start and end on a falling edge; one rising edge in between.
    task automatic wr(input logic [3:0] a, input logic [7:0] d);
        wr_en = 1'b1; addr = a; wr_data = d;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic rd(input logic [3:0] a);
        rd_en = 1'b1; addr = a;
        @(negedge clk);
        rd_en = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        idle(3);
        chk("rst_rd", rd_data, 8'h00);
        chk("rst_irq", irq, 1'b0);
        chk("rst_pads", {pad_a, pad_oe, pad_pu, pad_pd}, 32'h0);
        rst_n = 1'b1;
        idle(5);
        chk("pu_irq", irq, 1'b0);
        rd(4'd8);  chk("pu_din", rd_data, 8'h02);
        rd(4'd7);  chk("pu_stat", rd_data, 8'h00);

        wr(4'd1, 8'hFF); chk("pad_oe", pad_oe, 8'hFF);
        wr(4'd0, 8'hA5); chk("pad_a", pad_a, 8'hA5);
        wr(4'd2, 8'h0F); chk("pad_pu", pad_pu, 8'h0F);
        chk("pad_pd0", pad_pd, 8'h00);
        wr(4'd3, 8'hFF); chk("pad_pd", pad_pd, 8'hF0);
        rd(4'd0);  chk("rb_dout", rd_data, 8'hA5);
        rd(4'd1);  chk("rb_oe", rd_data, 8'hFF);
        rd(4'd2);  chk("rb_pu", rd_data, 8'h0F);
        rd(4'd3);  chk("rb_pd", rd_data, 8'hFF);
        rd(4'd12); chk("rb_hole", rd_data, 8'h00);
        wr(4'd8, 8'hFF);
        rd(4'd8);  chk("din_ro", rd_data, 8'h02);
        wr(4'd12, 8'hFF);
        rd(4'd1);  chk("hole_wr", rd_data, 8'hFF);
        rd_en = 1'b1;
        wr(4'd0, 8'h3C);
        rd_en = 1'b0;
        chk("rw_same", rd_data, 8'hA5);
        chk("rw_pad", pad_a, 8'h3C);

        // Sync latency, no debounce
        wr(4'd4, 8'h01);
        pad_y = 8'h03;
        idle(2);
        rd(4'd8);  chk("sync_e3_din", rd_data, 8'h02);
        chk("sync_e3_irq", irq, 1'b0);
        rd(4'd8);  chk("sync_e4_din", rd_data, 8'h03);
        chk("sync_e4_irq", irq, 1'b1);
        rd(4'd7);  chk("sync_stat", rd_data, 8'h01);
        wr(4'd7, 8'h01);
        chk("clr_irq_hold", irq, 1'b1);
        idle(1);
        chk("clr_irq_fall", irq, 1'b0);

        // Debounce on pin 1
        wr(4'd6, 8'h02);
        wr(4'd5, 8'h02);
        pad_y = 8'h01;
        idle(3);
        pad_y = 8'h03;
        idle(8);
        rd(4'd8);  chk("glitch_din", rd_data, 8'h03);
        chk("glitch_irq", irq, 1'b0);
        rd(4'd7);  chk("glitch_stat", rd_data, 8'h00);
        pad_y = 8'h01;
        idle(5);
        rd(4'd8);  chk("deb_e6_din", rd_data, 8'h03);
        chk("deb_e6_irq", irq, 1'b0);
        rd(4'd8);  chk("deb_e7_din", rd_data, 8'h01);
        chk("deb_e7_irq", irq, 1'b1);
        rd(4'd7);  chk("deb_stat", rd_data, 8'h02);
        wr(4'd7, 8'h02);
        idle(1);
        chk("deb_clr_irq", irq, 1'b0);

        // Set and clear colliding on pin 2
        wr(4'd4, 8'h05);
        pad_y = 8'h05;
        idle(4);
        rd(4'd7);  chk("col_pre", rd_data, 8'h04);
        pad_y = 8'h01;
        idle(4);
        pad_y = 8'h05;
        idle(2);
        wr(4'd7, 8'h04);
        rd(4'd7);  chk("col_set_wins", rd_data, 8'h04);
        wr(4'd7, 8'h04);
        rd(4'd7);  chk("col_clr", rd_data, 8'h00);

        // Async reset with pin 1 mid-debounce
        pad_y = 8'h00;
        idle(4);
        pad_y = 8'h05;
        idle(4);
        rd(4'd7);  chk("ar_stat", rd_data, 8'h05);
        chk("ar_irq_pre", irq, 1'b1);
        pad_y = 8'h07;
        idle(4);
        #1 rst_n = 1'b0;
        #1;
        chk("ar_irq", irq, 1'b0);
        chk("ar_rd", rd_data, 8'h00);
        chk("ar_pads", {pad_a, pad_oe, pad_pu, pad_pd}, 32'h0);
        idle(2);
        rst_n = 1'b1;
        wr(4'd6, 8'h02);
        idle(4);
        rd(4'd8);  chk("ar_e6_din", rd_data, 8'h05);
        rd(4'd8);  chk("ar_e7_din", rd_data, 8'h07);
        rd(4'd7);  chk("ar_post_stat", rd_data, 8'h00);
        chk("ar_post_irq", irq, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
